// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared widths and state encoding for the memory/writeback stage.
//   ADDR_W  data-memory and PC address width
//   DATA_W  datapath width
//   REG_AW  register-file address width
//   state_t IDLE (no access outstanding) / MEM (data-memory request in flight)
package mem_wb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    MEM  = 1'b1
  } state_t;

endpackage

// File: rtl/mem_wb_if.sv
// mem_wb_if: data-memory request/acknowledge bus.
//   master: drives dmem_req/we/addr/wdata, receives dmem_ack/rdata (the stage)
//   slave : the data memory
interface mem_wb_if;
  import mem_wb_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_wb_dmem_port.sv
// dmem_port: owns the IDLE/MEM state and the data-memory request registers,
// holding req/we/addr/wdata stable until the memory acknowledges.
//   clk, rst  clock, asynchronous active-high reset
//   launch_i  start a load/store this cycle (only honoured in IDLE)
//   we_i      1 = store
//   addr_i    request address
//   wdata_i   store data
//   busy_o    combinational: request outstanding (state is MEM)
//   done_o    combinational: memory acknowledges this cycle while in MEM
//   dmem      data-memory bus, master side
module dmem_port
  import mem_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              launch_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  mem_wb_if.master          dmem
);

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // State and request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state: launch from IDLE, hold everything in MEM until ack
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch_i) begin
          state_d = MEM;
          req_d   = 1'b1;
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = we_i ? wdata_i : wdata_q;
        end
      end
      MEM: begin
        if (dmem.dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          done_o  = 1'b1;
        end
      end
    endcase
  end

  assign busy_o          = (state_q == MEM);
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

endmodule

// File: rtl/mem_wb.sv
// mem_wb: memory/writeback stage. Accepts one result per cycle from ex,
// performs the data-memory handshake for loads/stores, drives the
// register-file write port and issues PC redirects.
//   clk, rst        clock, asynchronous active-high reset
//   v_i ... ctrl_st_i  instruction from ex (valid, result, store data, rd,
//                   writeback enable, branch taken, load, store)
//   stall_o         combinational: ex must hold while an access is outstanding
//   dmem            data-memory bus, master side
//   rf_we/addr/data_o  register-file write port (we is a one-cycle strobe)
//   pc_load/value_o    PC redirect (pc_load is a one-cycle strobe)
// Optional (MEM_WB_FWD_EN): fwd_valid/addr/data_o mirror the rf write port.
module mem_wb
  import mem_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              wb_en_i,
  input  logic              branch_en_i,
  input  logic              ctrl_ld_i,
  input  logic              ctrl_st_i,
  output logic              stall_o,
  mem_wb_if.master          dmem,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic              pc_load_o,
  output logic [ADDR_W-1:0] pc_value_o
`ifdef MEM_WB_FWD_EN
  ,
  output logic              fwd_valid_o,
  output logic [REG_AW-1:0] fwd_addr_o,
  output logic [DATA_W-1:0] fwd_data_o
`endif
);

  logic              busy_c, done_c;
  logic              accept_c, is_mem_c, launch_c;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              pc_load_q, pc_load_d;
  logic [ADDR_W-1:0] pc_value_q, pc_value_d;
  logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
  logic              ld_wb_q, ld_wb_d;
  logic              unused_c;

  // A taken branch overrides any ld/st flags; ld wins over st
  assign accept_c = v_i && !busy_c;
  assign is_mem_c = (ctrl_ld_i || ctrl_st_i) && !branch_en_i;
  assign launch_c = accept_c && is_mem_c;
  assign unused_c = ^result_i[DATA_W-1:ADDR_W];

  dmem_port u_dmem_port (
    .clk      (clk),
    .rst      (rst),
    .launch_i (launch_c),
    .we_i     (ctrl_st_i && !ctrl_ld_i),
    .addr_i   (result_i[ADDR_W-1:0]),
    .wdata_i  (st_data_i),
    .busy_o   (busy_c),
    .done_o   (done_c),
    .dmem     (dmem)
  );

  // Writeback, redirect and pending-load registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      pc_load_q  <= 1'b0;
      pc_value_q <= '0;
      ld_rd_q    <= '0;
      ld_wb_q    <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      pc_load_q  <= pc_load_d;
      pc_value_q <= pc_value_d;
      ld_rd_q    <= ld_rd_d;
      ld_wb_q    <= ld_wb_d;
    end
  end

  // Strobes default low; ALU writes and load completions never coincide
  // because accept only happens in IDLE and completion only in MEM
  always_comb begin
    rf_we_d    = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    pc_load_d  = 1'b0;
    pc_value_d = pc_value_q;
    ld_rd_d    = ld_rd_q;
    ld_wb_d    = ld_wb_q;
    if (launch_c) begin
      ld_rd_d = rd_addr_i;
      ld_wb_d = ctrl_ld_i && wb_en_i;
    end
    if (accept_c && !is_mem_c && wb_en_i) begin
      rf_we_d   = 1'b1;
      rf_addr_d = rd_addr_i;
      rf_data_d = result_i;
    end
    if (accept_c && branch_en_i) begin
      pc_load_d  = 1'b1;
      pc_value_d = result_i[ADDR_W-1:0];
    end
    if (done_c) begin
      ld_wb_d = 1'b0;
      if (ld_wb_q) begin
        rf_we_d   = 1'b1;
        rf_addr_d = ld_rd_q;
        rf_data_d = dmem.dmem_rdata;
      end
    end
  end

  assign stall_o    = busy_c;
  assign rf_we_o    = rf_we_q;
  assign rf_addr_o  = rf_addr_q;
  assign rf_data_o  = rf_data_q;
  assign pc_load_o  = pc_load_q;
  assign pc_value_o = pc_value_q;

`ifdef MEM_WB_FWD_EN
  // Same-cycle bypass of the rf write for the decode stage
  assign fwd_valid_o = rf_we_q;
  assign fwd_addr_o  = rf_addr_q;
  assign fwd_data_o  = rf_data_q;
`endif

endmodule

// File: doc/mem_wb.md
Name: mem_wb

Overview:
- Consumer end of the execute-stage result interface.
- Takes the registered result, rd address, writeback enable and branch enable from ex, and completes the instruction.
- Performs the data-memory load/store handshake, drives the register-file write port, and issues the PC redirect to fetch.
- Back-pressures ex through stall_o while a memory access is outstanding.

Parameters:
ADDR_W, 16, data-memory and PC address width
DATA_W, 32, datapath width
REG_AW, 4, register-file address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
v_i  in  1  inputs from ex valid this cycle
result_i  in  DATA_W  ex result: ALU value, memory address, or branch target
st_data_i  in  DATA_W  store data (rd value)
rd_addr_i  in  REG_AW  destination register
wb_en_i  in  1  write result or load data to rd
branch_en_i  in  1  taken branch
ctrl_ld_i  in  1  load instruction
ctrl_st_i  in  1  store instruction
stall_o  out  1  ex must hold its outputs
dmem_req_o  out  1  memory request, held until ack
dmem_we_o  out  1  1 = write
dmem_addr_o  out  ADDR_W  memory address
dmem_wdata_o  out  DATA_W  store data
dmem_ack_i  in  1  memory completes request this cycle
dmem_rdata_i  in  DATA_W  load data, valid with ack
rf_we_o  out  1  register-file write strobe
rf_addr_o  out  REG_AW  register-file write address
rf_data_o  out  DATA_W  register-file write data
pc_load_o  out  1  one-cycle PC redirect strobe
pc_value_o  out  ADDR_W  redirect target

Behaviour:
- Clock/reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE.
- All outputs are registered except stall_o, which is combinational from state.
- States:
  - IDLE: inputs are accepted when v_i=1.
  - MEM: request outstanding.
- Accept in IDLE with v_i=1:
  - ALU op (no ld/st): next cycle rf_we_o=wb_en_i, rf_addr_o=rd_addr_i, rf_data_o=result_i. Latency 1; state stays IDLE.
  - Load: next cycle dmem_req_o=1, dmem_we_o=0, dmem_addr_o=result_i[ADDR_W-1:0]; rd_addr_i and wb_en_i are latched; go to MEM.
  - Store: same as load, with dmem_we_o=1 and dmem_wdata_o=st_data_i; no rf write.
  - ctrl_ld_i and ctrl_st_i both set: treated as a load.
  - branch_en_i=1: next cycle pc_load_o=1, pc_value_o=result_i[ADDR_W-1:0]; pc_load_o is high for exactly one cycle.
  - Branch combined with ld/st is not legal; the branch is still issued and the ld/st is ignored.
  - Branch with wb_en_i and no ld/st: both the PC redirect and the rf write occur in the same cycle.
- MEM:
  - stall_o=1 for every cycle in MEM.
  - dmem_req_o, dmem_we_o, dmem_addr_o and dmem_wdata_o are held stable until dmem_ack_i.
  - v_i is ignored while in MEM.
  - On the cycle dmem_ack_i=1: drop dmem_req_o the next cycle and return to IDLE.
  - For a load with latched wb_en: next cycle rf_we_o=1, rf_addr_o=latched rd, rf_data_o=dmem_rdata_i.
  - A new instruction can be accepted on the first IDLE cycle after ack, so minimum load/store occupancy is 2 cycles.
- rf_we_o and pc_load_o are single-cycle strobes, cleared to 0 on the cycle after they assert.
- dmem_ack_i in IDLE is ignored; ack in the same cycle the request is launched cannot occur, because req is registered.
- rst asserted mid-MEM: request is abandoned; all outputs go to 0 immediately; no rf write occurs.
- rd address 0 is written like any other register; no special-casing.

Optional Feature:
MEM_WB_FWD_EN
- Defined: adds outputs fwd_valid_o (1 bit), fwd_addr_o (REG_AW) and fwd_data_o (DATA_W).
  - These mirror rf_we_o, rf_addr_o and rf_data_o combinationally in the same cycle, so the decode stage can bypass the register file.
  - fwd_valid_o is 0 during reset.
- Undefined: these ports are absent; writes become visible through the register file only.

Decomposition:
- Package mem_wb_pkg holds:
  - state encoding: IDLE=1'b0, MEM=1'b1
  - width constants ADDR_W, DATA_W, REG_AW
- One sub-module, dmem_port: owns the req/ack hold-until-ack registers and the MEM state.
- mem_wb keeps the rf and PC strobe logic.

Test Plan:
- ALU writeback: v_i=1, wb_en_i=1, rd=4'h3, result=32'h0000_00A5 -> next cycle rf_we_o=1, rf_addr_o=3, rf_data_o=32'hA5; stall_o stays 0.
- Load with 3 wait cycles: ld, result=32'h0000_0040, rd=4'h7, ack after 3 cycles with rdata=32'hDEAD_BEEF:
  - dmem_req_o=1 and addr=16'h0040 held stable for 3 cycles; stall_o=1 throughout.
  - Cycle after ack: rf_we_o=1 to r7 with 32'hDEADBEEF; req=0.
- Store: st, result=32'h0000_0010, st_data=32'h1234_5678, immediate ack -> one req cycle with we=1, addr=16'h0010, wdata=32'h12345678; rf_we_o never asserts.
- Branch: branch_en_i=1, result=32'h0000_0120 -> pc_load_o=1 for exactly one cycle with pc_value_o=16'h0120; a back-to-back ALU op the following cycle is accepted.
- Reset mid-load: rst pulse while in MEM before ack -> all outputs 0 at once; a later stray ack causes no rf write; the next op is accepted normally.
- (With MEM_WB_FWD_EN) ALU write to r5 -> fwd_valid_o=1, fwd_addr_o=5, fwd_data_o equal to rf_data_o in the same cycle.
